// File: rtl/serial_to_parallel_buf_if.sv
// Handshake bundle for serial_to_parallel_buf: beat input side, group output side.
// master = producer/consumer environment, slave = the buffer itself.
interface serial_to_parallel_buf_if #(
    parameter int WIDTH  = 32,
    parameter int N_OUTS = 4
);
    localparam int CW = $clog2(N_OUTS + 1);

    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        in_data;
    logic                    flush;
    logic                    out_valid;
    logic                    out_ready;
    logic [N_OUTS*WIDTH-1:0] out_data;
    logic [CW-1:0]           out_count;

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data, out_count
    );
endinterface

// File: rtl/serial_to_parallel_buf.sv
// Packs WIDTH-bit beats into groups of N_OUTS elements; flush closes a partial group.
// Optional S2P_DOUBLE_BUFFER_EN: two alternating fill banks for 1 beat/cycle throughput.
module serial_to_parallel_buf #(
    parameter int WIDTH  = 32,
    parameter int N_OUTS = 4
) (
    input logic                      clk,
    input logic                      rst,
    serial_to_parallel_buf_if.slave  bus
);
    localparam int CW = $clog2(N_OUTS + 1);
    localparam int PW = (N_OUTS > 1) ? $clog2(N_OUTS) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(N_OUTS - 1);

    typedef logic [N_OUTS-1:0][WIDTH-1:0] bank_t;

    logic          in_ready_int;
    logic          out_valid_int;
    logic          accept;
    logic          closing;
    logic [CW-1:0] close_count;
    logic [PW-1:0] wr_ptr_q;
    bank_t         cur_bank;
    bank_t         fill_next;
    bank_t         out_data_q;
    logic [CW-1:0] out_count_q;

    assign accept        = bus.in_valid & in_ready_int;
    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_int;
    assign bus.out_data  = out_data_q;
    assign bus.out_count = out_count_q;

    // A bank closes on its last beat, or on a flush that leaves at least one beat in it.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        fill_next   = cur_bank;
        closing     = 1'b0;
        close_count = CW'(wr_ptr_q);
        if (accept) begin
            fill_next[wr_ptr_q] = bus.in_data;
            close_count         = CW'(wr_ptr_q) + CW'(1);
            closing             = (wr_ptr_q == LAST_PTR) || bus.flush;
        end else if (bus.flush && in_ready_int && (wr_ptr_q != '0)) begin
            closing = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            wr_ptr_q <= '0;
        end else if (closing) begin
            wr_ptr_q <= '0;
        end else if (accept) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
        end
    end

`ifdef S2P_DOUBLE_BUFFER_EN
    // Closed bank waits in pend when the output register is busy and not draining.
    bank_t         banks_q [2];
    logic          fill_sel_q;
    logic          pend_q;
    logic [CW-1:0] pend_count_q;
    logic          out_valid_q;
    logic          out_free;

    assign cur_bank      = banks_q[fill_sel_q];
    assign in_ready_int  = ~pend_q;
    assign out_valid_int = out_valid_q;
    assign out_free      = ~out_valid_q | bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the banks are cleared on reset because unused elements must read as zero.
            banks_q      <= '{default: '0};
            fill_sel_q   <= 1'b0;
            pend_q       <= 1'b0;
            pend_count_q <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_count_q  <= '0;
        end else if (pend_q) begin
            if (bus.out_ready) begin
                out_data_q           <= banks_q[~fill_sel_q];
                out_count_q          <= pend_count_q;
                banks_q[~fill_sel_q] <= '0;
                pend_q               <= 1'b0;
            end
        end else if (closing) begin
            fill_sel_q <= ~fill_sel_q;
            if (out_free) begin
                out_data_q          <= fill_next;
                out_count_q         <= close_count;
                out_valid_q         <= 1'b1;
                banks_q[fill_sel_q] <= '0;
            end else begin
                banks_q[fill_sel_q] <= fill_next;
                pend_q              <= 1'b1;
                pend_count_q        <= close_count;
            end
        end else begin
            banks_q[fill_sel_q] <= fill_next;
            if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end
`else
    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0] state_q;
    bank_t      bank_q;

    assign cur_bank      = bank_q;
    assign in_ready_int  = (state_q == FILL);
    assign out_valid_int = (state_q == HOLD);

    // The bank is zeroed as it closes, so it is already clean when FILL is re-entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the bank is cleared on reset because unused elements must read as zero.
            state_q     <= FILL;
            bank_q      <= '0;
            out_data_q  <= '0;
            out_count_q <= '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (closing) begin
                        out_data_q  <= fill_next;
                        out_count_q <= close_count;
                        bank_q      <= '0;
                        state_q     <= HOLD;
                    end else begin
                        bank_q <= fill_next;
                    end
                end
                default: begin
                    if (bus.out_ready) begin
                        state_q <= FILL;
                    end
                end
            endcase
        end
    end
`endif

endmodule

// File: doc/serial_to_parallel_buf.md
# serial_to_parallel_buf

Collects a stream of `WIDTH`-bit beats into groups of `N_OUTS` elements and presents each complete group as one wide word. Both sides use valid/ready handshakes, and a flush input closes a partial group early. It sits between a pipelined producer issuing one element per cycle and a consumer that needs a whole vector per transaction, such as a wide SRAM write port or a shift buffer load.

## Interface
Parameters:
- `WIDTH`, 32: bits per element.
- `N_OUTS`, 4: elements per group; must be ≥ 1.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  producer has a beat.
- `in_ready`  out  1  block can accept a beat.
- `in_data`  in  WIDTH  beat payload.
- `flush`  in  1  close the current partial group; qualified by `in_ready`.
- `out_valid`  out  1  a group is presented.
- `out_ready`  in  1  consumer takes the group.
- `out_data`  out  N_OUTS*WIDTH  element i is at `[i*WIDTH +: WIDTH]`; the first beat received goes to element 0.
- `out_count`  out  $clog2(N_OUTS+1)  number of valid elements in `out_data` (1..N_OUTS).

## Operation
- Input accept: `in_valid & in_ready`. Output transfer: `out_valid & out_ready`.
- Fill bank:
  - Has a write pointer `wr_ptr` in 0..N_OUTS-1.
  - Each accepted beat is written at `wr_ptr`, then `wr_ptr` increments.
  - On the Nth beat, `wr_ptr` wraps to 0 and the bank is closed with count = N_OUTS.
- Flush:
  - Takes effect only in a cycle with `in_ready=1`.
  - If it coincides with an accept, that beat is included first, then the bank closes.
  - If the bank holds k>0 beats, it closes with count = k. Elements k..N_OUTS-1 read as 0.
  - If k=0 and there is no accept in the same cycle, flush is ignored and no empty group is produced.
  - If flush coincides with the Nth beat, exactly one group is produced, with count = N_OUTS.
- Closing a bank moves its data and count into the output register.
- State machine (base build):
  - FILL: `in_ready=1`, `out_valid=0`. Goes to HOLD when a bank closes.
  - HOLD: `in_ready=0`, `out_valid=1`. Goes to FILL on an output transfer.
- `out_data` and `out_count` stay stable while `out_valid & !out_ready`.
- On entering FILL, the fill bank is zeroed and `wr_ptr` is 0.
- `N_OUTS=1`: every accepted beat forms a group; flush has no visible effect.
- `rst` asserted at any time, including mid-group or during HOLD, discards all data. No partial group is emitted afterwards.

## Timing
- Reset values: `in_ready=1`, `out_valid=0`, `out_data=0`, `out_count=0`, `wr_ptr=0`, state FILL.
- Latency: the closing accept is at edge t, and `out_valid=1` is visible in the cycle after edge t.
- `in_ready` and `out_valid` are registered or decoded from state only. There is no combinational path from `out_ready` or `in_valid` to `in_ready`.
- Base build: after an output transfer at edge t, `in_ready=1` in the cycle after t. Peak throughput is N_OUTS beats per N_OUTS+1 cycles.
- `in_data` is sampled only on an accept edge. Data presented while `in_ready=0` is ignored.

## Configuration
- `S2P_DOUBLE_BUFFER_EN` defined:
  - Two fill banks alternate.
  - When a bank closes while the output register is free, or is freed at the same edge, the group moves to output and filling continues in the other bank with no bubble.
  - `in_ready=0` only when the output register is occupied and not draining and the fill bank has just closed.
  - Sustained throughput is 1 beat/cycle with `out_ready` held at 1.
  - Group order is preserved.
- Macro undefined: single bank and the FILL/HOLD machine above.

## Test plan
- WIDTH=8, N_OUTS=4, `out_ready=1`, beats 0x11,0x22,0x33,0x44 on consecutive cycles -> one cycle after the 4th accept, `out_valid=1`, `out_data=0x44332211`, `out_count=4`.
- Same config, 3 beats 0xA1,0xA2,0xA3 then `flush` with `in_valid=0` -> `out_data=0x00A3A2A1`, `out_count=3`. A further flush with no beats produces no group.
- 4 beats with `out_ready=0` for 5 cycles -> `out_valid` and `out_data` stay stable, and `in_ready=0` in the base build. Raising `out_ready` gives a transfer, then `in_ready=1` the next cycle.
- Assert `rst` after 2 beats, deassert, then send 4 beats 0x01..0x04 -> exactly one group, `0x04030201`, with no trace of the earlier beats.
- With `S2P_DOUBLE_BUFFER_EN`, 16 beats back-to-back with `out_ready=1` -> `in_ready` never drops, 4 groups arrive in order, and consecutive groups are 4 cycles apart.
- N_OUTS=1, WIDTH=16, beats 0xBEEF,0xCAFE -> two groups with `out_count=1`, each one cycle after its accept.
